fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage of the MIPS core, directly upstream of the instruction memory. It holds the program counter and drives the word-aligned fetch address to the combinational instruction memory. It captures the returned instruction into the IF/ID pipeline register, and applies stall, flush and branch/jump redirects from decode. It also detects the self-jump idiom used to terminate programs (`j` to its own address) and parks the core in a halted state.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset; must be word-aligned.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hazard unit: hold PC and IF/ID.
- `flush`  in  1  invalidate IF/ID, e.g. on an exception. PC advances normally.
- `branch_taken`  in  1  decode resolved a taken branch.
- `branch_target`  in  32  full branch target address.
- `jump`  in  1  decode holds a `j`/`jal`.
- `jump_index`  in  26  `instr[25:0]` of that jump.
- `imem_address`  out  32  fetch address to the instruction memory; equals `pc`.
- `imem_read_data`  in  32  instruction word, combinational from `imem_address`.
- `if_instr`  out  32  IF/ID instruction.
- `if_pc`  out  32  IF/ID PC of `if_instr`.
- `if_pc_plus4`  out  32  IF/ID PC+4.
- `if_valid`  out  1  IF/ID holds a real instruction.
- `halted`  out  1  self-jump detected; fetch frozen.
- `misaligned`  out  1  sticky flag: a redirect target had bits [1:0] ≠ 0.
- `fetch_count`  out  32  number of instructions loaded into IF/ID. Saturating.

## Operation
- State machine has two states: `RUN` and `HALT`. Reset enters `RUN`.
- Jump target is `{if_pc_plus4[31:28], jump_index, 2'b00}`.
- Branch target is `{branch_target[31:2], 2'b00}`. If `branch_target[1:0]` ≠ 0, `misaligned` is set and stays set until reset.
- Priority at each rising edge while in `RUN`:
  1. `jump`: `pc` ← jump target.
  2. `branch_taken`: `pc` ← branch target.
  3. For either redirect, IF/ID is bubbled: `if_valid`=0 and `if_instr`=0 (nop). A redirect overrides `stall`.
  4. `stall` with no redirect: `pc` and all IF/ID fields hold. `fetch_count` holds.
  5. Otherwise: `pc` ← `pc`+4, wrapping modulo 2^32.
     - `if_instr` ← `imem_read_data`, `if_pc` ← `pc`, `if_pc_plus4` ← `pc`+4.
     - `if_valid` ← !`flush`.
     - `fetch_count` increments when `if_valid` is loaded as 1, saturating at `32'hFFFF_FFFF`.
- `flush` together with `stall`: IF/ID is cleared (`if_valid`=0) and `pc` holds.
- Transition `RUN`→`HALT` happens at the edge where all of the following are true:
  - `if_valid`=1,
  - `if_instr[31:26]`=`6'b000010`,
  - `{if_pc_plus4[31:28], if_instr[25:0], 2'b00}` == `if_pc`,
  - `stall`=0.
- On that edge, `pc` ← `if_pc`, `if_valid` ← 0 and `halted` ← 1.
- In `HALT`, all inputs are ignored and all registers hold. Only `reset` exits.

## Timing
- Reset values, applied asynchronously:
  - `pc`=`RESET_PC`,
  - `if_instr`=0, `if_pc`=0, `if_pc_plus4`=0, `if_valid`=0,
  - `halted`=0, `misaligned`=0, `fetch_count`=0,
  - state `RUN`.
- `imem_address` is combinational from `pc`. The instruction at `pc` appears on `if_instr` one edge later: fetch latency is one cycle.
- Redirect-to-first-valid latency: target PC after edge N, its instruction valid in IF/ID after edge N+1. Exactly one bubble.
- Reset asserted mid-stall or mid-redirect: the reset values take effect immediately. The first fetch at `RESET_PC` is captured on the first edge after release.
- `halted` rises on the same edge as the state change. No further `fetch_count` change after that edge.

## Structure
- Shared package `mips_pkg`:
  - `OPC_J`=`6'b000010`, `OPC_JAL`=`6'b000011`,
  - `NOP_INSTR`=`32'h0`,
  - state enum `fetch_state_t {RUN, HALT}`.
- One sub-module: `if_id_reg`, holding the IF/ID register with enable (!stall), clear (flush/redirect) and async reset.
- PC, next-PC mux, halt FSM and counter stay in `fetch_unit`.

## Test plan
- Free run on the stock program, no stalls:
  - `imem_address` sequence is 0,4,8,… .
  - After edge 1: `if_instr`=`32'h20080002`, `if_pc`=0, `if_valid`=1.
  - After edge 3: `fetch_count`=3.
- `stall` held for 2 cycles at `pc`=8: `pc` stays 8 and `if_instr` holds `32'h200A0002` for both cycles. Fetch resumes at 8.
- `jump`=1, `jump_index`=6 while `if_pc_plus4`=`32'h24`: next `pc`=`32'h18` and `if_valid`=0 for one cycle. Then `if_instr`=`32'h01094022`.
- `branch_taken` and `stall` asserted together, `branch_target`=`32'h26`:
  - `pc`=`32'h24`, `misaligned`=1, bubble inserted.
  - Simultaneous `jump`+`branch_taken` → the jump target wins.
- Self-jump `32'h08000009` at `pc`=`32'h24`:
  - `halted`=1 one edge after it becomes valid in IF/ID; `pc` holds `32'h24`.
  - Later redirects and stalls have no effect.
  - `reset` returns `pc`=0 and `halted`=0.
- `flush` with `stall`=0: `if_valid`=0 and `pc` advances by 4. Async `reset` pulse mid-cycle clears all outputs without waiting for a clock edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcodes, the nop encoding, the fetch FSM
// state type and the pseudo-direct jump target helper.
package mips_pkg;

  localparam logic [5:0]  OPC_J     = 6'b000010;
  localparam logic [5:0]  OPC_JAL   = 6'b000011;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  // j/jal target: top nibble of the delay-slot PC, the index, word aligned.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [25:0] index);
    return {pc_plus4[31:28], index, 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Load on enable, bubble on clear (nop, invalid,
// PC fields kept), and kill drops only the valid bit (used when halting).
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  input  logic        kill,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] pc_plus4_in,
  input  logic        valid_in,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;

  // Next contents of the register: kill > clear > load > hold.
  always_comb begin
    // NOTE: every output gets a hold default first so no path can infer a latch.
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (kill) begin
      valid_d = 1'b0;
    end else if (clr) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (en) begin
      instr_d    = instr_in;
      pc_d       = pc_in;
      pc_plus4_d = pc_plus4_in;
      valid_d    = valid_in;
    end
  end

  // Register state with asynchronous reset to an empty slot.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (reset) begin
      instr_q    <= NOP_INSTR;
      pc_q       <= 32'h0;
      pc_plus4_q <= 32'h0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr    = instr_q;
  assign pc       = pc_q;
  assign pc_plus4 = pc_plus4_q;
  assign valid    = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, next-PC selection, IF/ID capture,
// fetch counter and the self-jump halt detector.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_read_data,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        if_valid,
  output logic        halted,
  output logic        misaligned,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         misaligned_q, misaligned_d;
  logic [31:0]  fetch_count_q, fetch_count_d;

  logic         running;
  logic         self_jump;
  logic         ifid_en, ifid_clr, ifid_kill, ifid_valid_in;

  // A valid `j` in IF/ID whose target is its own address ends the program.
  assign self_jump = if_valid && !stall && (if_instr[31:26] == OPC_J) &&
                     (jump_target(if_pc_plus4, if_instr[25:0]) == if_pc);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // FSM next state: HALT is absorbing until reset.
  always_comb begin
    state_d = state_q;
    if (state_q == RUN && self_jump) state_d = HALT;
  end

  // FSM outputs: halted is decoded from the state so it rises with it.
  always_comb begin
    running = (state_q == RUN);
    halted  = (state_q == HALT);
  end

  // Next PC, IF/ID controls, sticky misalignment flag and fetch counter.
  always_comb begin
    pc_d          = pc_q;
    misaligned_d  = misaligned_q;
    fetch_count_d = fetch_count_q;
    ifid_en       = 1'b0;
    ifid_clr      = 1'b0;
    ifid_kill     = 1'b0;
    ifid_valid_in = !flush;
    if (running) begin
      if (self_jump) begin
        pc_d      = if_pc;
        ifid_kill = 1'b1;
      end else if (jump) begin
        pc_d     = jump_target(if_pc_plus4, jump_index);
        ifid_clr = 1'b1;
      end else if (branch_taken) begin
        pc_d     = {branch_target[31:2], 2'b00};
        ifid_clr = 1'b1;
        if (branch_target[1:0] != 2'b00) misaligned_d = 1'b1;
      end else if (stall) begin
        // A flush during a stall still empties IF/ID; the PC holds.
        ifid_clr = flush;
      end else begin
        pc_d    = pc_q + 32'd4;
        ifid_en = 1'b1;
        if (!flush && fetch_count_q != COUNT_MAX) fetch_count_d = fetch_count_q + 32'd1;
      end
    end
  end

  // PC, flag and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      misaligned_q  <= 1'b0;
      fetch_count_q <= 32'h0;
    end else begin
      pc_q          <= pc_d;
      misaligned_q  <= misaligned_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  if_id_reg u_if_id (
    .clk         (clk),
    .reset       (reset),
    .en          (ifid_en),
    .clr         (ifid_clr),
    .kill        (ifid_kill),
    .instr_in    (imem_read_data),
    .pc_in       (pc_q),
    .pc_plus4_in (pc_q + 32'd4),
    .valid_in    (ifid_valid_in),
    .instr       (if_instr),
    .pc          (if_pc),
    .pc_plus4    (if_pc_plus4),
    .valid       (if_valid)
  );

  assign imem_address = pc_q;
  assign misaligned   = misaligned_q;
  assign fetch_count  = fetch_count_q;

endmodule
